// File: rtl/otn_frame_tx_arq_pkg.sv
// Shared serial framing constants and FSM encoding for the OTN frame link.
// The receive-side sampler imports the same values.
package otn_frame_tx_arq_pkg;

    localparam logic START_BIT          = 1'b0;
    localparam logic STOP_BIT           = 1'b1;
    localparam int   BITS_PER_CHAR      = 10;
    localparam int   DEFAULT_BIT_CYCLES = 868;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/otn_byte_serializer.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held
// BIT_CYCLES cycles. Accepts the next byte during the last stop-bit cycle.
module otn_byte_serializer
    import otn_frame_tx_arq_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_line,
    output logic       o_char_done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;
    logic             bit_end;

    assign bit_end     = busy && (bit_cnt == CNT_W'(BIT_CYCLES - 1));
    assign o_char_done = bit_end && (bit_idx == 4'(BITS_PER_CHAR - 1));
    // Ready in the final stop-bit cycle keeps consecutive bytes gapless.
    assign o_ready     = !busy || o_char_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            o_line  <= STOP_BIT;
        end else if (i_valid && o_ready) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= {STOP_BIT, i_byte};
            o_line  <= START_BIT;
        end else if (o_char_done) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            o_line  <= STOP_BIT;
        end else if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            o_line  <= shreg[0];
            shreg   <= {STOP_BIT, shreg[8:1]};
        end else if (busy) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/otn_frame_tx_arq.sv
// Frame buffer + serial sender with optional ACK/timeout retransmission.
// One frame is held at a time; it is resent from byte 0 on each retry.
module otn_frame_tx_arq
    import otn_frame_tx_arq_pkg::*;
#(
    parameter int FRAME_BYTES = 64,
    parameter int BIT_CYCLES  = DEFAULT_BIT_CYCLES,
    parameter int ACK_TIMEOUT = 200000,
    parameter int MAX_RETRIES = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [7:0]                         i_frame_data,
    input  logic                               i_frame_data_valid,
    output logic                               o_frame_data_ready,
    input  logic                               i_arq_en,
    output logic                               o_otn_tx_data,
    input  logic                               i_otn_rx_ack,
    output logic                               o_frame_done,
    output logic                               o_frame_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt
);

    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RC_W  = $clog2(MAX_RETRIES + 1);

    state_t           state;
    logic [7:0]       frame_buf [FRAME_BYTES];
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             last_fed, arq_lat;
    logic [TO_W-1:0]  to_cnt;
    logic [2:0]       ack_sync;

    logic       in_hs, load_last, ack_edge, timeout, retry, kick;
    logic       ser_valid, ser_ready, ser_done, frame_sent;
    logic [7:0] ser_data;

    assign in_hs     = i_frame_data_valid && o_frame_data_ready;
    assign load_last = (state == ST_LOAD) && in_hs && (wr_idx == IDX_W'(FRAME_BYTES - 1));
    assign ack_edge  = ack_sync[1] && !ack_sync[2];
    assign timeout   = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign retry     = (state == ST_WAIT_ACK) && !ack_edge && timeout
                       && (o_retry_cnt < RC_W'(MAX_RETRIES));
    // Byte 0 is handed over on the cycle before SEND so its start bit lands
    // on the first SEND cycle.
    assign kick      = load_last || retry;
    assign ser_valid = kick || ((state == ST_SEND) && !last_fed);
    assign ser_data  = !kick ? frame_buf[rd_idx] :
                       ((state == ST_LOAD) && (wr_idx == '0)) ? i_frame_data : frame_buf[0];
    assign frame_sent = (state == ST_SEND) && last_fed && ser_done;

    otn_byte_serializer #(.BIT_CYCLES(BIT_CYCLES)) u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_byte      (ser_data),
        .i_valid     (ser_valid),
        .o_ready     (ser_ready),
        .o_line      (o_otn_tx_data),
        .o_char_done (ser_done)
    );

    always_ff @(posedge i_clk) begin
        if ((state == ST_LOAD) && in_hs)
            frame_buf[wr_idx] <= i_frame_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ack_sync <= '0;
        else       ack_sync <= {ack_sync[1:0], i_otn_rx_ack};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state              <= ST_LOAD;
            o_frame_data_ready <= 1'b0;
            wr_idx             <= '0;
            rd_idx             <= '0;
            last_fed           <= 1'b0;
            arq_lat            <= 1'b0;
            to_cnt             <= '0;
            o_retry_cnt        <= '0;
            o_frame_done       <= 1'b0;
            o_frame_fail       <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_frame_fail <= 1'b0;
            if (kick) begin
                rd_idx   <= (FRAME_BYTES > 1) ? IDX_W'(1) : '0;
                last_fed <= (FRAME_BYTES == 1);
            end
            case (state)
                ST_LOAD: begin
                    o_frame_data_ready <= 1'b1;
                    if (in_hs) begin
                        if (load_last) begin
                            wr_idx             <= '0;
                            arq_lat            <= i_arq_en;
                            o_frame_data_ready <= 1'b0;
                            state              <= ST_SEND;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (ser_valid && ser_ready) begin
                        if (rd_idx == IDX_W'(FRAME_BYTES - 1)) last_fed <= 1'b1;
                        else                                   rd_idx   <= rd_idx + IDX_W'(1);
                    end
                    if (frame_sent) begin
                        if (arq_lat) begin
                            to_cnt <= '0;
                            state  <= ST_WAIT_ACK;
                        end else begin
                            o_frame_done       <= 1'b1;
                            o_retry_cnt        <= '0;
                            o_frame_data_ready <= 1'b1;
                            state              <= ST_LOAD;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_edge) begin
                        o_frame_done       <= 1'b1;
                        o_retry_cnt        <= '0;
                        o_frame_data_ready <= 1'b1;
                        state              <= ST_LOAD;
                    end else if (timeout) begin
                        if (retry) begin
                            o_retry_cnt <= o_retry_cnt + RC_W'(1);
                            state       <= ST_SEND;
                        end else begin
                            o_frame_fail       <= 1'b1;
                            o_retry_cnt        <= '0;
                            o_frame_data_ready <= 1'b1;
                            state              <= ST_LOAD;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_otn_frame_tx_arq.sv
// Self-checking bench: random frames against a bit-timeline model of the link.
module tb_otn_frame_tx_arq;

    localparam int FB = 4;
    localparam int BC = 4;
    localparam int TO = 50;
    localparam int MR = 2;
    localparam int SEND_LEN = FB * 10 * BC;

    typedef logic [7:0] frame_t [FB];

    logic       i_clk, i_rst;
    logic [7:0] i_frame_data;
    logic       i_frame_data_valid, o_frame_data_ready, i_arq_en;
    logic       o_otn_tx_data, i_otn_rx_ack, o_frame_done, o_frame_fail;
    logic [1:0] o_retry_cnt;

    int checks = 0;
    int errors = 0;

    bit cap_line[$], cap_done[$], cap_fail[$], cap_ready[$];
    int cap_retry[$];
    bit exp_line[$];

    otn_frame_tx_arq #(.FRAME_BYTES(FB), .BIT_CYCLES(BC), .ACK_TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_data(i_frame_data),
        .i_frame_data_valid(i_frame_data_valid), .o_frame_data_ready(o_frame_data_ready),
        .i_arq_en(i_arq_en), .o_otn_tx_data(o_otn_tx_data), .i_otn_rx_ack(i_otn_rx_ack),
        .o_frame_done(o_frame_done), .o_frame_fail(o_frame_fail), .o_retry_cnt(o_retry_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: each byte is start 0, data LSB first, stop 1, each bit BC cycles.
    function automatic void exp_frame(input frame_t fr);
        for (int b = 0; b < FB; b++)
            for (int bit_n = 0; bit_n < 10; bit_n++)
                for (int c = 0; c < BC; c++)
                    exp_line.push_back(bit_n == 0 ? 1'b0 : bit_n == 9 ? 1'b1 : fr[b][bit_n-1]);
    endfunction

    function automatic void exp_idle(input int n);
        for (int i = 0; i < n; i++) exp_line.push_back(1'b1);
    endfunction

    task automatic rand_frame(output frame_t fr);
        for (int i = 0; i < FB; i++) fr[i] = 8'($urandom);
    endtask

    task automatic clear_cap();
        cap_line.delete(); cap_done.delete(); cap_fail.delete();
        cap_ready.delete(); cap_retry.delete(); exp_line.delete();
    endtask

    // Called at a negedge; returns at the negedge just after the last handshake.
    task automatic push_frame(input frame_t fr, input logic arq);
        i_arq_en = arq;
        for (int i = 0; i < FB; i++) begin
            int guard = 0;
            i_frame_data = fr[i];
            i_frame_data_valid = 1'b1;
            while (!o_frame_data_ready && guard < 1000) begin
                @(negedge i_clk);
                guard++;
            end
            if (guard >= 1000) begin
                checks++; errors++;
                $display("FAIL push_timeout byte %0d: ready never rose", i);
            end
            @(negedge i_clk);
        end
        i_frame_data_valid = 1'b0;
    endtask

    task automatic capture(input int n, input int on1, input int len1, input int on2, input int len2);
        for (int k = 0; k < n; k++) begin
            i_otn_rx_ack = (k >= on1 && k < on1 + len1) || (k >= on2 && k < on2 + len2);
            cap_line.push_back(o_otn_tx_data);
            cap_done.push_back(o_frame_done);
            cap_fail.push_back(o_frame_fail);
            cap_ready.push_back(o_frame_data_ready);
            cap_retry.push_back(int'(o_retry_cnt));
            @(negedge i_clk);
        end
        i_otn_rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #1;
        checks++; if (o_otn_tx_data !== 1'b1) begin errors++; $display("FAIL reset_line got %b want 1", o_otn_tx_data); end
        checks++; if (o_frame_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_frame_data_ready); end
        checks++; if ({o_frame_done, o_frame_fail} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {o_frame_done, o_frame_fail}); end
        checks++; if (o_retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", o_retry_cnt); end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++; if (o_frame_data_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk got %b want 0", o_frame_data_ready); end
        @(negedge i_clk);
        checks++; if (o_frame_data_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk got %b want 1", o_frame_data_ready); end
    endtask

    task automatic test_arq_off();
        frame_t fr;
        fr[0] = 8'hA5; fr[1] = 8'h3C; fr[2] = 8'hFF; fr[3] = 8'h00;
        for (int it = 0; it < 2; it++) begin
            int ndone = 0;
            if (it == 1) rand_frame(fr);
            push_frame(fr, 1'b0);
            clear_cap();
            capture(SEND_LEN + 10, 0, 0, 0, 0);
            exp_frame(fr);
            exp_idle(10);
            for (int k = 0; k < SEND_LEN + 10; k++) begin
                checks++;
                if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL off_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
                if (cap_done[k]) ndone++;
            end
            checks++; if (ndone != 1 || cap_done[SEND_LEN] !== 1'b1) begin errors++; $display("FAIL off_done count %0d at_end %b want 1 at %0d", ndone, cap_done[SEND_LEN], SEND_LEN); end
            checks++; if (cap_ready[SEND_LEN/2] !== 1'b0) begin errors++; $display("FAIL off_ready_send got %b want 0", cap_ready[SEND_LEN/2]); end
            checks++; if (cap_ready[SEND_LEN] !== 1'b1) begin errors++; $display("FAIL off_ready_back got %b want 1", cap_ready[SEND_LEN]); end
        end
    endtask

    task automatic test_ack_first();
        frame_t fr;
        for (int it = 0; it < 2; it++) begin
            int r = (it == 0) ? 10 : int'($urandom_range(0, 40));
            int ack_at = SEND_LEN + r;
            int n = ack_at + 20;
            int ndone = 0, nfail = 0, didx = -1;
            rand_frame(fr);
            push_frame(fr, 1'b1);
            clear_cap();
            capture(n, ack_at, 2, 0, 0);
            exp_frame(fr);
            exp_idle(n - SEND_LEN);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL ack_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
                checks++;
                if (cap_retry[k] != 0) begin errors++; $display("FAIL ack_retry cyc %0d got %0d want 0", k, cap_retry[k]); end
                if (cap_done[k]) begin ndone++; didx = k; end
                if (cap_fail[k]) nfail++;
            end
            checks++; if (ndone != 1 || didx < ack_at + 2 || didx > ack_at + 3) begin errors++; $display("FAIL ack_done count %0d at %0d want 1 in [%0d,%0d]", ndone, didx, ack_at + 2, ack_at + 3); end
            checks++; if (nfail != 0) begin errors++; $display("FAIL ack_fail count %0d want 0", nfail); end
        end
    endtask

    task automatic test_no_ack();
        frame_t fr;
        int n = 3 * (SEND_LEN + TO) + 15;
        int ndone = 0, nfail = 0, fidx = -1;
        rand_frame(fr);
        push_frame(fr, 1'b1);
        clear_cap();
        capture(n, 0, 0, 0, 0);
        for (int a = 0; a < 3; a++) begin exp_frame(fr); exp_idle(TO); end
        exp_idle(15);
        for (int k = 0; k < n; k++) begin
            int want_rc = (k >= 3 * (SEND_LEN + TO)) ? 0 : k / (SEND_LEN + TO);
            checks++;
            if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL noack_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
            checks++;
            if (cap_retry[k] != want_rc) begin errors++; $display("FAIL noack_retry cyc %0d got %0d want %0d", k, cap_retry[k], want_rc); end
            if (cap_done[k]) ndone++;
            if (cap_fail[k]) begin nfail++; fidx = k; end
        end
        checks++; if (nfail != 1 || fidx != 3 * (SEND_LEN + TO)) begin errors++; $display("FAIL noack_fail count %0d at %0d want 1 at %0d", nfail, fidx, 3 * (SEND_LEN + TO)); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL noack_done count %0d want 0", ndone); end
    endtask

    task automatic test_ack_after_retry();
        frame_t fr;
        int ack_at = 2 * SEND_LEN + TO + int'($urandom_range(0, 45));
        int n = 2 * (SEND_LEN + TO) + 60;
        int ndone = 0, nfail = 0, didx = -1;
        rand_frame(fr);
        push_frame(fr, 1'b1);
        clear_cap();
        // The first pulse lands during SEND and must be ignored.
        capture(n, 50, 3, ack_at, 2);
        exp_frame(fr); exp_idle(TO); exp_frame(fr);
        exp_idle(n - exp_line.size());
        for (int k = 0; k < n; k++) begin
            checks++;
            if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL retry_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
            if (k >= SEND_LEN + TO && k <= ack_at + 1) begin
                checks++;
                if (cap_retry[k] != 1) begin errors++; $display("FAIL retry_cnt cyc %0d got %0d want 1", k, cap_retry[k]); end
            end else if (k < SEND_LEN + TO || k >= ack_at + 4) begin
                checks++;
                if (cap_retry[k] != 0) begin errors++; $display("FAIL retry_clr cyc %0d got %0d want 0", k, cap_retry[k]); end
            end
            if (cap_done[k]) begin ndone++; didx = k; end
            if (cap_fail[k]) nfail++;
        end
        checks++; if (ndone != 1 || didx < ack_at + 2 || didx > ack_at + 3) begin errors++; $display("FAIL retry_done count %0d at %0d want 1 in [%0d,%0d]", ndone, didx, ack_at + 2, ack_at + 3); end
        checks++; if (nfail != 0) begin errors++; $display("FAIL retry_fail count %0d want 0", nfail); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q8 [8];
        frame_t f1, f2;
        int acc [8];
        int ptr = 0;
        int n = 2 * (FB + SEND_LEN) + 12;
        for (int i = 0; i < 8; i++) begin q8[i] = 8'($urandom); acc[i] = -1; end
        for (int i = 0; i < FB; i++) begin f1[i] = q8[i]; f2[i] = q8[i+4]; end
        i_arq_en = 1'b0;
        clear_cap();
        for (int k = 0; k < n; k++) begin
            i_frame_data_valid = (ptr < 8);
            i_frame_data = (ptr < 8) ? q8[ptr] : 8'h00;
            cap_line.push_back(o_otn_tx_data);
            cap_ready.push_back(o_frame_data_ready);
            if (i_frame_data_valid && o_frame_data_ready) begin acc[ptr] = k; ptr++; end
            @(negedge i_clk);
        end
        i_frame_data_valid = 1'b0;
        exp_idle(FB); exp_frame(f1); exp_idle(FB); exp_frame(f2);
        exp_idle(n - exp_line.size());
        for (int k = 0; k < n; k++) begin
            bit want_rdy = (k < FB) || (k >= FB + SEND_LEN && k < 2 * FB + SEND_LEN) || (k >= 2 * (FB + SEND_LEN));
            checks++;
            if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL b2b_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
            checks++;
            if (cap_ready[k] !== want_rdy) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", k, cap_ready[k], want_rdy); end
        end
        for (int i = 0; i < 8; i++) begin
            int want = (i < 4) ? i : SEND_LEN + i;
            checks++;
            if (acc[i] != want) begin errors++; $display("FAIL b2b_accept byte %0d at %0d want %0d", i, acc[i], want); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t fr;
        int hold = 10 + int'($urandom_range(0, 20));
        int ndone = 0;
        rand_frame(fr);
        fr[0] = 8'h00;
        push_frame(fr, 1'b0);
        repeat (hold) @(negedge i_clk);
        checks++; if (o_otn_tx_data !== 1'b0) begin errors++; $display("FAIL mid_line_pre got %b want 0", o_otn_tx_data); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_otn_tx_data !== 1'b1) begin errors++; $display("FAIL mid_line_async got %b want 1", o_otn_tx_data); end
        checks++; if (o_frame_data_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_rst got %b want 0", o_frame_data_ready); end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++; if (o_frame_data_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", o_frame_data_ready); end
        clear_cap();
        capture(SEND_LEN + 40, 0, 0, 0, 0);
        for (int k = 0; k < SEND_LEN + 40; k++) begin
            checks++;
            if (cap_line[k] !== 1'b1 || cap_done[k] !== 1'b0) begin errors++; $display("FAIL mid_idle cyc %0d line %b done %b want 1 0", k, cap_line[k], cap_done[k]); end
        end
        rand_frame(fr);
        push_frame(fr, 1'b0);
        clear_cap();
        capture(SEND_LEN + 4, 0, 0, 0, 0);
        exp_frame(fr); exp_idle(4);
        for (int k = 0; k < SEND_LEN + 4; k++) begin
            checks++;
            if (cap_line[k] !== exp_line[k]) begin errors++; $display("FAIL mid_next_line cyc %0d got %b want %b", k, cap_line[k], exp_line[k]); end
            if (cap_done[k]) ndone++;
        end
        checks++; if (ndone != 1 || cap_done[SEND_LEN] !== 1'b1) begin errors++; $display("FAIL mid_next_done count %0d want 1 at %0d", ndone, SEND_LEN); end
    endtask

    initial begin
        i_rst = 1'b1;
        i_frame_data = 8'h00;
        i_frame_data_valid = 1'b0;
        i_arq_en = 1'b0;
        i_otn_rx_ack = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_arq_off();
        test_ack_first();
        test_no_ack();
        test_ack_after_retry();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otn_frame_tx_arq.md
Name: otn_frame_tx_arq

Overview:
Transmit-side serial frame sender, directly upstream of the receive path's serial receiver/ACK transmitter. It buffers one complete frame of bytes from the framer/mapper and serializes it onto the inter-FPGA data line. With ARQ enabled, it waits for an ACK pulse on the return line and retransmits the buffered frame on timeout, up to a retry limit. Sits between the transmit mapper and the board pin driving the receive path's serial data input.

Parameters:
FRAME_BYTES, 64, bytes per frame; buffer depth; power of two not required
BIT_CYCLES, 868, i_clk cycles per serial bit (100 MHz / 115200)
ACK_TIMEOUT, 200000, cycles after last stop bit to wait for ACK before retransmit
MAX_RETRIES, 3, retransmissions after the first attempt before declaring failure

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_frame_data  in  8  frame byte from mapper
i_frame_data_valid  in  1  byte valid
o_frame_data_ready  out  1  block accepts byte (AXI-stream style)
i_arq_en  in  1  1 = wait for ACK and retransmit; sampled at start of each frame send
o_otn_tx_data  out  1  serial line to receiver, idle high
i_otn_rx_ack  in  1  asynchronous ACK line from receiver, idle low
o_frame_done  out  1  one-cycle pulse: frame delivered (ACKed, or sent with ARQ off)
o_frame_fail  out  1  one-cycle pulse: retries exhausted, frame dropped
o_retry_cnt  out  $clog2(MAX_RETRIES+1)  retransmissions of the current frame

Behaviour:
- Reset (async, active-high): state LOAD; o_otn_tx_data=1; o_frame_data_ready=0 until the first clock after deassertion; o_frame_done=0; o_frame_fail=0; o_retry_cnt=0; byte and bit counters 0; ACK synchronizer flops 0.
- Reset mid-frame: the line returns to 1 immediately (asynchronously); the buffer contents are discarded.
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly BIT_CYCLES cycles. There is no gap between bytes within a frame.
- ACK input passes through a 2-flop synchronizer, then a rising-edge detector. Only rising edges seen in WAIT_ACK count; edges in other states are ignored.
- FSM:
  - LOAD:
    - ready=1.
    - Each valid&&ready writes buf[wr_idx] and increments wr_idx.
    - When the byte with wr_idx==FRAME_BYTES-1 is accepted, go to SEND the next cycle. Ready drops in the same cycle the state changes.
    - Latch i_arq_en at this transition.
  - SEND:
    - ready=0.
    - The start bit of byte 0 drives the line on the first SEND cycle, i.e. one cycle after the last byte handshake.
    - rd_idx steps 0..FRAME_BYTES-1.
    - After the last stop bit completes:
      - arq latched=1: go to WAIT_ACK, timeout counter=0.
      - arq latched=0: pulse o_frame_done, clear o_retry_cnt, go to LOAD.
  - WAIT_ACK:
    - line=1; timeout counter increments each cycle.
    - ACK edge before counter reaches ACK_TIMEOUT-1: pulse o_frame_done, clear o_retry_cnt, go to LOAD.
    - Counter reaches ACK_TIMEOUT-1 with no edge:
      - retry_cnt<MAX_RETRIES: increment retry_cnt, go to SEND from rd_idx=0 with the same buffer.
      - otherwise: pulse o_frame_fail, clear retry_cnt, go to LOAD.
    - Simultaneous ACK edge and timeout: ACK wins.
- Total send time per attempt: FRAME_BYTES*10*BIT_CYCLES cycles exactly.
- Counters: bit-cycle counter width $clog2(BIT_CYCLES); bit index 0..9; byte indices width $clog2(FRAME_BYTES). All wrap only via explicit clears, never by natural overflow.
- o_frame_done and o_frame_fail are never high together and never high for more than one cycle.
- Only one frame is held at a time: the next frame is not accepted until the current one is done or failed.

Decomposition:
- Shared package: serial framing constants (START_BIT=0, STOP_BIT=1, BITS_PER_CHAR=10), FSM state encoding (LOAD, SEND, WAIT_ACK), and the default BIT_CYCLES, so the receive-side sampler uses identical values.
- Natural sub-module: otn_byte_serializer. Interface: i_clk/i_rst, byte in with valid/ready, o_line, o_char_done pulse; owns the bit-cycle and bit-index counters.
- The frame buffer is an inferred register/distributed RAM array in the top module.

Test Plan:
(Bench uses BIT_CYCLES=4, FRAME_BYTES=4, ACK_TIMEOUT=50, MAX_RETRIES=2.)
1. ARQ off, load 0xA5,0x3C,0xFF,0x00 back-to-back -> line is 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first with framing), then the other three bytes, each bit 4 cycles; send lasts 160 cycles; o_frame_done pulses 1 cycle after the last stop bit; ready returns to 1.
2. ARQ on, ACK pulse 10 cycles after the last stop bit -> one transmission only; o_frame_done pulses 2–3 cycles after the edge (synchronizer latency); o_retry_cnt=0.
3. ARQ on, no ACK -> three identical 160-cycle transmissions separated by 50 idle-high cycles; o_retry_cnt goes 1, then 2; o_frame_fail pulses once; o_frame_done never pulses.
4. ARQ on, ACK only after the first timeout -> exactly two transmissions; o_retry_cnt=1 at the ACK, then cleared; o_frame_done pulses.
5. Valid held high with 8 bytes queued -> only 4 accepted; ready=0 throughout SEND; bytes 5–8 are accepted only after o_frame_done.
6. Assert i_rst asynchronously mid-byte -> o_otn_tx_data=1 within the same cycle; after release, ready=1 and the partial frame is never transmitted.
